// File: rtl/riscv_pkg.sv
// riscv_pkg: decoder type bit positions, forwarding/state encodings and operand-use helpers.
package riscv_pkg;
  localparam int TYPE_BITS   = 9;
  localparam int TYPE_R      = 8;
  localparam int TYPE_IALU   = 7;
  localparam int TYPE_LOAD   = 6;
  localparam int TYPE_STORE  = 5;
  localparam int TYPE_BRANCH = 4;
  localparam int TYPE_JAL    = 3;
  localparam int TYPE_LUI    = 2;
  localparam int TYPE_AUIPC  = 1;
  localparam int TYPE_JALR   = 0;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  typedef enum logic [1:0] {
    SEQ_RUN   = 2'b00,
    SEQ_STALL = 2'b01,
    SEQ_FLUSH = 2'b10
  } seq_state_e;
  typedef struct packed {
    logic       wen;
    logic       is_load;
    logic [4:0] rd;
  } shadow_t;
  localparam shadow_t SHADOW_EMPTY = '{wen: 1'b0, is_load: 1'b0, rd: 5'd0};
  function automatic logic uses_rs1(input logic [TYPE_BITS-1:0] t);
    return t[TYPE_R] | t[TYPE_IALU] | t[TYPE_LOAD] | t[TYPE_STORE] | t[TYPE_BRANCH] | t[TYPE_JALR];
  endfunction
  function automatic logic uses_rs2(input logic [TYPE_BITS-1:0] t);
    return t[TYPE_R] | t[TYPE_STORE] | t[TYPE_BRANCH];
  endfunction
  function automatic logic writes_rd(input logic [TYPE_BITS-1:0] t);
    return t[TYPE_R] | t[TYPE_IALU] | t[TYPE_LOAD] | t[TYPE_JAL] | t[TYPE_LUI] | t[TYPE_AUIPC] | t[TYPE_JALR];
  endfunction
  function automatic logic hit(input shadow_t s, input logic used, input logic [4:0] rs);
    return used && s.wen && s.rd == rs;
  endfunction
  // m = {EX, MEM, WB} matches; an EX-stage load cannot supply its value from MEM next cycle.
  function automatic logic [1:0] fwd_sel(input logic [2:0] m, input logic ex_load);
    return (m[2] && !ex_load) ? FWD_MEM : m[1] ? FWD_WB : FWD_REG;
  endfunction
endpackage

// File: rtl/hazard_sequencer_if.sv
// hazard_sequencer_if: ID-stage decode inputs and pipeline control outputs of the hazard sequencer.
interface hazard_sequencer_if #(
  parameter int CNT_W  = 16,
  parameter int TYPE_W = 9
);
  logic              id_valid;
  logic [TYPE_W-1:0] id_type;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic              ex_redirect;
  logic              stall_if;
  logic              stall_id;
  logic              flush_id;
  logic              flush_ex;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [1:0]        seq_state;
  logic [CNT_W-1:0]  stall_count;
  modport master (
    output id_valid, id_type, id_rs1, id_rs2, id_rd, ex_redirect,
    input  stall_if, stall_id, flush_id, flush_ex, fwd_a, fwd_b, seq_state, stall_count
  );
  modport slave (
    input  id_valid, id_type, id_rs1, id_rs2, id_rd, ex_redirect,
    output stall_if, stall_id, flush_id, flush_ex, fwd_a, fwd_b, seq_state, stall_count
  );
endinterface

// File: rtl/pipe_shadow_reg.sv
// pipe_shadow_reg: destination-register shadow for one pipeline stage; bubble_i loads an empty slot.
module pipe_shadow_reg
  import riscv_pkg::*;
(
  input  logic    clock,
  input  logic    reset_n,
  input  logic    bubble_i,
  input  shadow_t shadow_i,
  output shadow_t shadow_o
);
  shadow_t shadow_q, shadow_d;
  always_comb shadow_d = bubble_i ? SHADOW_EMPTY : shadow_i;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) shadow_q <= SHADOW_EMPTY;
    else shadow_q <= shadow_d;
  assign shadow_o = shadow_q;
endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: ID-stage hazard detection, stall/flush control and EX forwarding selects.
// Define FORWARDING_EN to forward from MEM/WB and stall only on load-use.
module hazard_sequencer
  import riscv_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int TYPE_W = 9
) (
  input logic               clock,
  input logic               reset_n,
  hazard_sequencer_if.slave bus
);
  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TYPE_W-1:0] id_type;
  shadow_t           id_sh, ex_sh, mem_sh, wb_sh;
  logic              squash, id_live, use1, use2, hazard, bubble, unused_bits;
  logic [2:0]        m1, m2;
  logic [1:0]        fwd_a, fwd_b;
  assign id_type = bus.id_type;
  // A redirect, or the cycle after one, leaves only a squashed instruction in ID.
  always_comb begin
    squash  = bus.ex_redirect || state_q == SEQ_FLUSH;
    id_live = bus.id_valid && |id_type && !squash;
    use1    = id_live && uses_rs1(id_type) && bus.id_rs1 != 5'd0;
    use2    = id_live && uses_rs2(id_type) && bus.id_rs2 != 5'd0;
    id_sh   = '{wen: id_live && writes_rd(id_type) && bus.id_rd != 5'd0,
                is_load: id_live && id_type[TYPE_LOAD], rd: bus.id_rd};
    m1      = {hit(ex_sh, use1, bus.id_rs1), hit(mem_sh, use1, bus.id_rs1), hit(wb_sh, use1, bus.id_rs1)};
    m2      = {hit(ex_sh, use2, bus.id_rs2), hit(mem_sh, use2, bus.id_rs2), hit(wb_sh, use2, bus.id_rs2)};
  end
`ifdef FORWARDING_EN
  assign hazard      = ex_sh.is_load && (m1[2] || m2[2]);
  assign fwd_a       = fwd_sel(m1, ex_sh.is_load);
  assign fwd_b       = fwd_sel(m2, ex_sh.is_load);
  assign unused_bits = ^{m1[0], m2[0], mem_sh.is_load, wb_sh};
`else
  assign hazard      = |{m1, m2};
  assign fwd_a       = FWD_REG;
  assign fwd_b       = FWD_REG;
  assign unused_bits = ^{ex_sh.is_load, mem_sh.is_load, wb_sh.is_load};
`endif
  assign bubble = hazard || bus.ex_redirect;
  pipe_shadow_reg u_ex  (.clock(clock), .reset_n(reset_n), .bubble_i(bubble), .shadow_i(id_sh),  .shadow_o(ex_sh));
  pipe_shadow_reg u_mem (.clock(clock), .reset_n(reset_n), .bubble_i(1'b0),   .shadow_i(ex_sh),  .shadow_o(mem_sh));
  pipe_shadow_reg u_wb  (.clock(clock), .reset_n(reset_n), .bubble_i(1'b0),   .shadow_i(mem_sh), .shadow_o(wb_sh));
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= SEQ_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = bus.ex_redirect ? SEQ_FLUSH : hazard ? SEQ_STALL : SEQ_RUN;
    cnt_d   = (hazard && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // Shadows are cleared in reset, so only the flush outputs need explicit gating.
  always_comb begin
    bus.stall_if    = hazard;
    bus.stall_id    = hazard;
    bus.flush_id    = reset_n && bus.ex_redirect;
    bus.flush_ex    = reset_n && bus.ex_redirect;
    bus.fwd_a       = fwd_a;
    bus.fwd_b       = fwd_b;
    bus.seq_state   = state_q;
    bus.stall_count = cnt_q;
  end
endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed table plus randomized checks against an issue-history reference model.
`timescale 1ns/1ps
module tb_hazard_sequencer;
  localparam logic [8:0] T_R = 9'h100, T_I = 9'h080, T_LD = 9'h040, T_ST = 9'h020, T_BR = 9'h010;
  localparam logic [8:0] T_JAL = 9'h008, T_LUI = 9'h004, T_AUI = 9'h002, T_JALR = 9'h001, T_NOP = 9'h000;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  hazard_sequencer_if #(.CNT_W(16), .TYPE_W(9)) bus ();
  hazard_sequencer_if #(.CNT_W(2), .TYPE_W(9)) bus2 ();
  hazard_sequencer #(.CNT_W(16), .TYPE_W(9)) dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));
  hazard_sequencer #(.CNT_W(2), .TYPE_W(9)) dut2 (.clock(clock), .reset_n(reset_n), .bus(bus2.slave));
  always #5 clock = ~clock;

  // Reference: the last three instructions issued into EX, youngest first (rd=0 means no write).
  typedef struct {int rd; bit ld;} slot_t;
  slot_t pipe[3];
  bit prev_red, prev_stall;
  int cnt;

  typedef struct {bit v; logic [8:0] t; int r1; int r2; int rd; bit red; bit s; int fa; int fb;} vec_t;
  vec_t vt[$];

  function automatic bit uses1(input logic [8:0] t);
    return t inside {T_R, T_I, T_LD, T_ST, T_BR, T_JALR};
  endfunction
  function automatic bit uses2(input logic [8:0] t);
    return t inside {T_R, T_ST, T_BR};
  endfunction
  function automatic bit writes(input logic [8:0] t);
    return t inside {T_R, T_I, T_LD, T_JAL, T_LUI, T_AUI, T_JALR};
  endfunction
  function automatic int nearest(input int rs, input bit used);
    for (int k = 0; k < 3; k++) if (used && pipe[k].rd == rs) return k;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) pipe[k] = '{0, 1'b0};
    prev_red = 1'b0;
    prev_stall = 1'b0;
    cnt = 0;
  endtask

  task automatic drive(input bit v, input logic [8:0] t, input int r1, input int r2, input int rd, input bit red);
    bus.id_valid = v;  bus.id_type = t;  bus.id_rs1 = 5'(r1);  bus.id_rs2 = 5'(r2);  bus.id_rd = 5'(rd);  bus.ex_redirect = red;
    bus2.id_valid = v; bus2.id_type = t; bus2.id_rs1 = 5'(r1); bus2.id_rs2 = 5'(r2); bus2.id_rd = 5'(rd); bus2.ex_redirect = red;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_stall_if"}, bus.stall_if, 0);
    chk({tag, "_stall_id"}, bus.stall_id, 0);
    chk({tag, "_flush_id"}, bus.flush_id, 0);
    chk({tag, "_flush_ex"}, bus.flush_ex, 0);
    chk({tag, "_fwd_a"}, bus.fwd_a, 0);
    chk({tag, "_fwd_b"}, bus.fwd_b, 0);
    chk({tag, "_seq_state"}, bus.seq_state, 0);
    chk({tag, "_stall_count"}, bus.stall_count, 0);
    chk({tag, "_stall_count2"}, bus2.stall_count, 0);
  endtask

  // One clock: drive ID at edge+1, check mid-cycle against model (and table row if tab), then advance.
  task automatic cycle(input bit v, input logic [8:0] t, input int r1, input int r2, input int rd, input bit red,
                       input bit tab, input bit ts, input int tfa, input int tfb);
    bit squash, live, u1, u2, s;
    int k1, k2, fa, fb;
    slot_t issued;
    drive(v, t, r1, r2, rd, red);
    squash = red || prev_red;
    live = v && t != 9'h0 && !squash;
    u1 = live && uses1(t) && r1 != 0;
    u2 = live && uses2(t) && r2 != 0;
    k1 = nearest(r1, u1);
    k2 = nearest(r2, u2);
    if (FWD) begin
      s  = pipe[0].ld && (k1 == 0 || k2 == 0);
      fa = k1 == 0 ? 1 : k1 == 1 ? 2 : 0;
      fb = k2 == 0 ? 1 : k2 == 1 ? 2 : 0;
    end else begin
      s  = k1 >= 0 || k2 >= 0;
      fa = 0;
      fb = 0;
    end
    #4;
    chk("stall_id", bus.stall_id, s);
    chk("stall_if", bus.stall_if, s);
    chk("flush_id", bus.flush_id, red);
    chk("flush_ex", bus.flush_ex, red);
    if (!s) begin
      chk("fwd_a", bus.fwd_a, fa);
      chk("fwd_b", bus.fwd_b, fb);
    end
    chk("seq_state", bus.seq_state, prev_red ? 2 : prev_stall ? 1 : 0);
    chk("stall_count", bus.stall_count, cnt);
    chk("stall_count_sat", bus2.stall_count, cnt > 3 ? 3 : cnt);
    if (tab) begin
      chk("tab_stall", bus.stall_id, ts);
      if (!ts) begin
        chk("tab_fwd_a", bus.fwd_a, tfa);
        chk("tab_fwd_b", bus.fwd_b, tfb);
      end
    end
    @(posedge clock);
    issued.rd = (!s && live && writes(t)) ? rd : 0;
    issued.ld = !s && live && t == T_LD;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = issued;
    if (s && cnt < 65535) cnt++;
    prev_red = red;
    prev_stall = s;
    #1;
  endtask

  initial begin
    int ti;
    logic [8:0] rt;
    model_reset();
    drive(1'b1, T_R, 5, 5, 6, 1'b1);
    #2;
    check_zero("reset");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    // ADDI then dependent ADD
    vt.push_back('{1'b1, T_I, 0, 0, 5, 1'b0, 1'b0, 0, 0});
    vt.push_back('{1'b1, T_R, 5, 5, 6, 1'b0, !FWD, FWD ? 1 : 0, FWD ? 1 : 0});
    vt.push_back('{1'b1, T_R, 5, 5, 6, 1'b0, !FWD, FWD ? 2 : 0, FWD ? 2 : 0});
    for (int i = 0; i < 3; i++) vt.push_back('{1'b0, T_NOP, 0, 0, 0, 1'b0, 1'b0, 0, 0});
    // load-use
    vt.push_back('{1'b1, T_LD, 1, 0, 5, 1'b0, 1'b0, 0, 0});
    vt.push_back('{1'b1, T_R, 5, 0, 6, 1'b0, 1'b1, 0, 0});
    vt.push_back('{1'b1, T_R, 5, 0, 6, 1'b0, !FWD, FWD ? 2 : 0, 0});
    vt.push_back('{1'b1, T_R, 5, 0, 6, 1'b0, !FWD, 0, 0});
    vt.push_back('{1'b1, T_R, 5, 0, 6, 1'b0, 1'b0, 0, 0});
    for (int i = 0; i < 3; i++) vt.push_back('{1'b1, T_NOP, 0, 0, 0, 1'b0, 1'b0, 0, 0});
    // redirect beats load-use hazard
    vt.push_back('{1'b1, T_LD, 1, 0, 5, 1'b0, 1'b0, 0, 0});
    vt.push_back('{1'b1, T_R, 5, 0, 6, 1'b1, 1'b0, 0, 0});
    vt.push_back('{1'b1, T_R, 5, 0, 6, 1'b0, 1'b0, 0, 0});
    for (int i = 0; i < 3; i++) vt.push_back('{1'b0, T_R, 5, 5, 5, 1'b0, 1'b0, 0, 0});
    // x0 never matches; store rs2 forwarding
    vt.push_back('{1'b1, T_I, 0, 0, 0, 1'b0, 1'b0, 0, 0});
    vt.push_back('{1'b1, T_R, 0, 0, 1, 1'b0, 1'b0, 0, 0});
    vt.push_back('{1'b1, T_I, 0, 0, 7, 1'b0, 1'b0, 0, 0});
    vt.push_back('{1'b1, T_ST, 2, 7, 0, 1'b0, !FWD, 0, FWD ? 1 : 0});
    for (int i = 0; i < 3; i++) vt.push_back('{1'b0, T_NOP, 0, 0, 0, 1'b0, 1'b0, 0, 0});
    foreach (vt[i]) cycle(vt[i].v, vt[i].t, vt[i].r1, vt[i].r2, vt[i].rd, vt[i].red, 1'b1, vt[i].s, vt[i].fa, vt[i].fb);
    for (int i = 0; i < 600; i++) begin
      ti = int'($urandom_range(0, 9));
      rt = ti == 9 ? 9'h0 : 9'h1 << ti;
      cycle($urandom_range(0, 9) != 0, rt, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), $urandom_range(0, 9) == 0, 1'b0, 1'b0, 0, 0);
    end
    if (cnt >= 3) chk("stall_count_saturated", bus2.stall_count, 3);
    for (int i = 0; i < 3; i++) cycle(1'b0, T_NOP, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    // reset asserted in the middle of a stall
    cycle(1'b1, T_LD, 1, 0, 5, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b1, T_R, 5, 0, 6, 1'b0);
    #2;
    chk("pre_reset_stall", bus.stall_id, 1);
    reset_n = 1'b0;
    drive(1'b1, T_R, 5, 0, 6, 1'b1);
    #1;
    check_zero("mid_reset");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
    cycle(1'b1, T_R, 5, 0, 6, 1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, T_NOP, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
